spi_master_engine: RTL
======================

Name: spi_master_engine

Overview:
- Serialises one 16-bit command per transfer onto a shared SPI bus with 10 chip selects.
- Upstream is the sensor/DAC configuration sequencer, which presents command, ss, CPOL and CPHA, raises trigger, and waits for ready.
- Drives sclk, mosi and cs_n to the board devices and captures miso into rx_data for readback.

Parameters:
- CLK_DIV, 4, sclk half-period in clock cycles; legal values ≥2.
- LSB_FIRST, 1, 1 = command[0] shifted first; 0 = command[15] shifted first.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- command  input  16  word to transmit; sampled at transfer start.
- ss  input  10  one-hot (or multi-hot) target select, 1 = selected; sampled at start.
- trigger  input  1  start request; rising edge only.
- CPOL  input  1  sclk idle level; sampled at start.
- CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at start.
- ready  output  1  1 = idle, able to accept a transfer.
- sclk  output  1  SPI clock.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.
- cs_n  output  10  active-low chip selects, equal to ~ss_latched during a transfer.
- rx_data  output  16  word captured from miso, in the same bit order as transmit.
- rx_valid  output  1  one-cycle pulse when rx_data updates.

Behaviour:
- Reset values: ready=1, sclk=0, mosi=0, cs_n=10'h3FF, rx_data=0, rx_valid=0, state=IDLE, trigger_d=0. Reset mid-transfer aborts immediately; no rx_valid is produced.
- Start condition: trigger & ~trigger_d & (state==IDLE), evaluated in cycle T. trigger_d is trigger registered every cycle. A trigger held high across several cycles or across the end of a transfer does not start a second transfer.
- At the T edge, latch command, ss, CPOL and CPHA. From T+1: ready=0, cs_n=~ss_l, sclk=CPOL_l, and state=SETUP.
- States: IDLE → SETUP → SHIFT → HOLD → RECOVER → IDLE. One divider counter counts 0..CLK_DIV-1; each terminal count is a "tick".
- SETUP (1 tick): for CPHA_l=0, mosi already shows the first bit. For CPHA_l=1, mosi is unchanged until the first edge.
- SHIFT (32 ticks): sclk toggles on every tick.
  - Odd ticks are leading edges; even ticks are trailing edges.
  - CPHA_l=0: sample miso on leading edges; shift mosi to the next bit on trailing edges, except after the 16th bit.
  - CPHA_l=1: drive mosi on leading edges; sample miso on trailing edges.
  - A 5-bit bit counter ends SHIFT after 16 samples. sclk ends at CPOL_l.
- HOLD (1 tick): cs_n still asserted, sclk=CPOL_l.
- RECOVER (1 tick): cs_n=3FF, mosi=0.
- End of transfer: ready=1 and rx_valid=1 in cycle T+1+35*CLK_DIV, with rx_data updated in the same cycle. For CLK_DIV=4 this is cycle T+141.
- ss=0: the full transfer and timing still run; cs_n stays 3FF.
- trigger edges while busy are ignored and are not queued.
- Inputs (command, ss, CPOL, CPHA) may change freely while busy; only the latched copies are used.
- rx_data holds its value until the next successful completion.

Test Plan:
- Reset, then command=16'h0001, ss=10'b10, CPOL=0, CPHA=0, LSB_FIRST=1 → cs_n=10'h3FD from T+1 to T+136; mosi=1 for the first bit only; ready rises at T+141.
- Loopback miso=mosi with command=16'hA5C3, CPHA=0 → rx_data=16'hA5C3 and one rx_valid pulse.
- Loopback with command=16'hA5C3, CPHA=1 → rx_data=16'hA5C3.
- CPOL=1, ss=10'b0010000000, command=16'h1F → sclk idles high, exactly 16 rising and 16 falling edges, cs_n=10'h37F during the transfer.
- Hold trigger high for 11 cycles, then for 200 cycles → exactly one transfer per rising edge; no restart when ready returns while trigger is still high.
- Assert reset at cycle T+60 mid-transfer → the next cycle shows cs_n=3FF, sclk=0, ready=1, and no rx_valid. A fresh trigger after reset completes normally.

Source files
------------

// File: rtl/spi_master_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_engine
// Description : Single-word (16-bit) SPI master with 10 chip selects,
//               run-time CPOL/CPHA, and a fixed sclk divider.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_engine #(
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] command,
    input  logic [9:0]  ss,
    input  logic        trigger,
    input  logic        CPOL,
    input  logic        CPHA,
    output logic        ready,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic [9:0]  cs_n,
    output logic [15:0] rx_data,
    output logic        rx_valid
);

    localparam int                 DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]         LAST_EDGE = 5'd31;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    // Maps the k-th bit on the wire to its position in the 16-bit word.
    function automatic logic [3:0] bit_pos(input logic [3:0] k);
        if (LSB_FIRST) return k;
        else           return 4'd15 - k;
    endfunction

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       edge_cnt;   // sclk edges completed in SHIFT
    logic             trigger_d;
    logic [15:0]      tx_word;
    logic [15:0]      rx_buf;
    logic             cpol_l;
    logic             cpha_l;
    logic             tick;
    logic             start;
    logic             leading;
    logic [3:0]       cur_bit;
    logic [3:0]       next_bit;

    assign tick     = (div_cnt == DIV_LAST);
    assign start    = trigger & ~trigger_d & (state == ST_IDLE);
    // Edges alternate leading/trailing, starting with a leading edge.
    assign leading  = ~edge_cnt[0];
    assign cur_bit  = bit_pos(edge_cnt[4:1]);
    assign next_bit = bit_pos(edge_cnt[4:1] + 4'd1);

    // Trigger history for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) trigger_d <= 1'b0;
        else       trigger_d <= trigger;
    end

    // Shared divider: free-runs while busy, parked at zero when idle.
    always_ff @(posedge clock) begin
        if (reset || state == ST_IDLE || tick) div_cnt <= '0;
        else                                   div_cnt <= div_cnt + 1'b1;
    end

    // Transfer sequencer and SPI pin drivers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            edge_cnt <= '0;
            tx_word  <= '0;
            rx_buf   <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_word  <= command;
                        cpol_l   <= CPOL;
                        cpha_l   <= CPHA;
                        cs_n     <= ~ss;
                        sclk     <= CPOL;
                        ready    <= 1'b0;
                        edge_cnt <= '0;
                        state    <= ST_SETUP;
                        // Mode 0/2 must present the first bit before the first edge.
                        if (!CPHA) mosi <= command[bit_pos(4'd0)];
                    end
                end
                ST_SETUP: begin
                    if (tick) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 5'd1;
                        if (leading) begin
                            if (!cpha_l) rx_buf[cur_bit] <= miso;
                            else         mosi <= tx_word[cur_bit];
                        end else begin
                            if (cpha_l)                      rx_buf[cur_bit] <= miso;
                            else if (edge_cnt != LAST_EDGE)  mosi <= tx_word[next_bit];
                        end
                        if (edge_cnt == LAST_EDGE) state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        sclk  <= cpol_l;
                        cs_n  <= '1;
                        mosi  <= 1'b0;
                        state <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (tick) begin
                        ready    <= 1'b1;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_buf;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
